onehot_decoder_stream: RTL and testbench
========================================

Name: onehot_decoder_stream

Overview:
- Streaming binary-to-one-hot decoder with valid/ready handshakes on both sides. It is the inverse of the team's 4-to-2 one-hot encoder.
- Accepts a binary code, produces the matching one-hot word through a registered 2-entry output buffer, and counts illegal codes.
- Sits between a code-producing block (arbiter grant index, FSM select) and one-hot consumers that may stall.

Parameters:
- IN_W, 2, width of binary input code.
- OUT_N, 4, number of one-hot output lines; legal range 1..2**IN_W.
- ERR_CNT_W, 8, width of saturating illegal-code counter.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream code valid.
- in_ready  output  1  decoder can accept this cycle.
- in  input  IN_W  binary code.
- out_valid  output  1  head entry valid.
- out_ready  input  1  downstream accepts head entry.
- out  output  OUT_N  one-hot word; bit k set when code == k.
- out_err  output  1  head entry carries an illegal code.
- err_clr  input  1  synchronous clear of err_count.
- err_count  output  ERR_CNT_W  saturating count of accepted illegal codes.

Behaviour:
- Reset (async assert, sync release):
  - Buffer count 0, out_valid 0, out all zeros, out_err 0, err_count 0.
  - in_ready is 1 on the first edge after release.
- Accept: in_valid && in_ready at a rising edge. Pop: out_valid && out_ready at a rising edge.
- Decode at accept time:
  - in < OUT_N: entry = one-hot with bit[in] set, err 0.
  - in >= OUT_N: entry = all zeros, err 1.
  - Stored word is never partially hot and never has more than one bit set.
- Buffer is a 2-entry FIFO of {word, err}:
  - in_ready = (count < 2), a registered function of count only; no combinational path from out_ready.
  - out_valid = (count > 0); out and out_err always show the head entry.
  - Empty, out_valid 0: out and out_err hold 0.
- Latency: out_valid rises on the edge after the accepting edge. Throughput: 1 code per cycle while out_ready is held high.
- Simultaneous events:
  - Push and pop in the same cycle with count 1: count stays 1; the new entry becomes head next cycle.
  - Push and pop with count 2: not possible, because in_ready is 0.
  - Pop with count 0: ignored.
- Outputs stay stable while out_valid && !out_ready, since the head is unchanged until popped.
- err_count:
  - Increments by 1 on each accepted illegal code and saturates at all-ones.
  - err_clr alone: next value 0.
  - err_clr together with an illegal accept in the same cycle: next value 1.
  - The counter changes on accept, not on pop.
- Reset mid-operation flushes both entries immediately: out_valid drops asynchronously and buffered codes are lost.
- Flag an elaboration-time error if OUT_N > 2**IN_W or OUT_N < 1.

Optional Feature:
- Macro: DECODER_PARITY_EN.
- Defined:
  - Adds input port in_par (1 bit), expected in_par == ^in (even parity over in plus in_par).
  - A parity mismatch on accept is treated as illegal: entry all zeros, err 1, err_count increments.
  - A code that is both out-of-range and parity-bad counts once.
- Undefined: port absent, no parity check; behaviour as above.

Test Plan:
- Reset then stream in=0,1,2,3 with out_ready=1 and in_valid held → out=0001,0010,0100,1000 on consecutive cycles starting 1 cycle after first accept; out_err=0; err_count=0.
- out_ready=0, push 2 then 3 → in_ready drops to 0 after second accept, count 2, out holds 0100. Raise out_ready → 0100 then 1000 pop; in_ready returns to 1.
- Instance OUT_N=3, IN_W=2, accept in=3 → out=000, out_err=1, err_count=1. Repeat 300 times with ERR_CNT_W=8 → err_count saturates at 255.
- err_count=5, assert err_clr in the same cycle as an illegal accept → err_count=1. err_clr alone → 0.
- Buffer full, assert rst_n=0 mid-cycle → out_valid=0 and out=0000 without waiting for clk. After release, in_ready=1 and count=0.
- With DECODER_PARITY_EN: in=1, in_par=0 → out=0000, out_err=1, err_count +1. in=1, in_par=1 → out=0010, out_err=0.

Source files
------------

// File: rtl/onehot_decoder_stream.sv
// ---------------------------------------------------------------------------
// onehot_decoder_stream
//
// Streaming binary-to-one-hot decoder. A binary code is accepted on a
// valid/ready handshake, decoded at accept time and stored in a 2-entry FIFO.
// The FIFO head drives the one-hot output. Illegal codes are counted by a
// saturating counter. An illegal code is out of range, or, when parity is
// enabled, fails the parity check. An illegal code is stored as an all-zero
// word with out_err set.
//
// Parameters:
//   IN_W      width of the binary input code
//   OUT_N     number of one-hot output lines (1 .. 2**IN_W)
//   ERR_CNT_W width of the saturating illegal-code counter
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset (assert async, release sync)
//   in_valid   upstream code valid
//   in_ready   decoder can accept this cycle (registered, depends on fill only)
//   in         binary code
//   in_par     (DECODER_PARITY_EN only) even parity bit, expected == ^in
//   out_valid  head entry valid
//   out_ready  downstream accepts head entry
//   out        one-hot word of the head entry (zero when empty)
//   out_err    head entry carries an illegal code (zero when empty)
//   err_clr    synchronous clear of err_count
//   err_count  saturating count of accepted illegal codes
//
// Optional feature macro: DECODER_PARITY_EN (adds in_par and the parity check)
// ---------------------------------------------------------------------------
module onehot_decoder_stream #(
  parameter int IN_W      = 2,
  parameter int OUT_N     = 4,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_W-1:0]      in,
`ifdef DECODER_PARITY_EN
  input  logic                 in_par,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_N-1:0]     out,
  output logic                 out_err,
  input  logic                 err_clr,
  output logic [ERR_CNT_W-1:0] err_count
);

  generate
    if (OUT_N < 1 || OUT_N > (2 ** IN_W)) begin : g_bad_param
      $error("onehot_decoder_stream: OUT_N must lie in 1 .. 2**IN_W");
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Decode. Each output line compares the code against its own index. A
  // code with no matching line is out of range. Out-of-range and
  // parity-bad codes raise the same single error flag, so a code that is
  // both is counted only once.
  // ---------------------------------------------------------------------
  logic [OUT_N-1:0] code_hit;
  logic [OUT_N-1:0] dec_word;
  logic             dec_err;
  logic             par_bad;

  generate
    for (genvar gi = 0; gi < OUT_N; gi++) begin : g_hit
      assign code_hit[gi] = (in == IN_W'(gi));
      assign dec_word[gi] = code_hit[gi] & ~dec_err;
    end
  endgenerate

`ifdef DECODER_PARITY_EN
  assign par_bad = (in_par != (^in));
`else
  assign par_bad = 1'b0;
`endif

  assign dec_err = ~(|code_hit) | par_bad;

  // ---------------------------------------------------------------------
  // 2-entry FIFO held as an explicit head/tail pair. The head register is
  // zeroed whenever the FIFO drains. That lets out/out_err come straight
  // from flops and still read zero while empty.
  // ---------------------------------------------------------------------
  logic [1:0]           count_reg, count_next;
  logic [OUT_N-1:0]     head_word_reg, head_word_next;
  logic                 head_err_reg, head_err_next;
  logic [OUT_N-1:0]     tail_word_reg, tail_word_next;
  logic                 tail_err_reg, tail_err_next;
  logic                 in_ready_reg, in_ready_next;
  logic [ERR_CNT_W-1:0] err_count_reg, err_count_next;

  logic push;
  logic pop;
  logic push_illegal;

  assign out_valid    = (count_reg != 2'd0);
  assign in_ready     = in_ready_reg;
  assign out          = head_word_reg;
  assign out_err      = head_err_reg;
  assign err_count    = err_count_reg;

  assign push         = in_valid & in_ready_reg;
  assign pop          = out_valid & out_ready;
  assign push_illegal = push & dec_err;

  always_comb begin
    count_next     = count_reg;
    head_word_next = head_word_reg;
    head_err_next  = head_err_reg;
    tail_word_next = tail_word_reg;
    tail_err_next  = tail_err_reg;

    case (count_reg)
      2'd0: begin
        if (push) begin
          head_word_next = dec_word;
          head_err_next  = dec_err;
          count_next     = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          // The old head leaves and the new code takes its place.
          head_word_next = dec_word;
          head_err_next  = dec_err;
        end else if (push) begin
          tail_word_next = dec_word;
          tail_err_next  = dec_err;
          count_next     = 2'd2;
        end else if (pop) begin
          head_word_next = '0;
          head_err_next  = 1'b0;
          count_next     = 2'd0;
        end
      end
      2'd2: begin
        // A push cannot happen here because in_ready is low.
        if (pop) begin
          head_word_next = tail_word_reg;
          head_err_next  = tail_err_reg;
          tail_word_next = '0;
          tail_err_next  = 1'b0;
          count_next     = 2'd1;
        end
      end
      default: begin
        count_next     = 2'd0;
        head_word_next = '0;
        head_err_next  = 1'b0;
        tail_word_next = '0;
        tail_err_next  = 1'b0;
      end
    endcase

    // in_ready is registered from the next fill level. This keeps out_ready
    // out of any combinational path to in_ready.
    in_ready_next = (count_next < 2'd2);
  end

  // A clear that coincides with an illegal accept leaves exactly that one.
  always_comb begin
    err_count_next = err_count_reg;
    if (err_clr) begin
      err_count_next = push_illegal ? ERR_CNT_W'(1) : '0;
    end else if (push_illegal && !(&err_count_reg)) begin
      err_count_next = err_count_reg + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg     <= 2'd0;
      head_word_reg <= '0;
      head_err_reg  <= 1'b0;
      tail_word_reg <= '0;
      tail_err_reg  <= 1'b0;
      in_ready_reg  <= 1'b1;
      err_count_reg <= '0;
    end else begin
      count_reg     <= count_next;
      head_word_reg <= head_word_next;
      head_err_reg  <= head_err_next;
      tail_word_reg <= tail_word_next;
      tail_err_reg  <= tail_err_next;
      in_ready_reg  <= in_ready_next;
      err_count_reg <= err_count_next;
    end
  end

endmodule

// File: tb/tb_onehot_decoder_stream.sv
// ---------------------------------------------------------------------------
// tb_onehot_decoder_stream
//
// Drives two decoder instances from the same stimulus. The first is the
// default build (OUT_N=4). The second uses OUT_N=3, so code 3 is illegal
// there. Each instance has a scoreboard queue. The expected {err, word} is
// pushed when a code is accepted and compared while it is the head. It is
// popped when the downstream side takes it. An error-count model follows
// the accept and clear rules.
// ---------------------------------------------------------------------------
module tb_onehot_decoder_stream;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       out_ready;
  logic       err_clr;
  logic [1:0] code;
`ifdef DECODER_PARITY_EN
  logic       in_par;
`endif

  logic       in_ready4, out_valid4, out_err4;
  logic [3:0] out4;
  logic [7:0] err_count4;
  logic       in_ready3, out_valid3, out_err3;
  logic [2:0] out3;
  logic [7:0] err_count3;

  int n_checks = 0;
  int n_fail   = 0;

  logic [4:0] q4[$];
  logic [4:0] q3[$];
  int         ecnt4 = 0;
  int         ecnt3 = 0;

  onehot_decoder_stream #(.IN_W(2), .OUT_N(4), .ERR_CNT_W(8)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready4),
    .in        (code),
`ifdef DECODER_PARITY_EN
    .in_par    (in_par),
`endif
    .out_valid (out_valid4),
    .out_ready (out_ready),
    .out       (out4),
    .out_err   (out_err4),
    .err_clr   (err_clr),
    .err_count (err_count4)
  );

  onehot_decoder_stream #(.IN_W(2), .OUT_N(3), .ERR_CNT_W(8)) dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready3),
    .in        (code),
`ifdef DECODER_PARITY_EN
    .in_par    (in_par),
`endif
    .out_valid (out_valid3),
    .out_ready (out_ready),
    .out       (out3),
    .out_err   (out_err3),
    .err_clr   (err_clr),
    .err_count (err_count3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Expected entry {err, word} for a code on an OUT_N = n instance.
  function automatic logic [4:0] model(input logic [1:0] c, input logic par_ok, input int n);
    logic [3:0] w;
    if ((int'(c) < n) && par_ok) begin
      w = 4'b0001 << c;
      return {1'b0, w};
    end
    return 5'b10000;
  endfunction

  task automatic set_code(input logic [1:0] c);
    code = c;
`ifdef DECODER_PARITY_EN
    in_par = ^c;
`endif
  endtask

  function automatic int err_model(input int cur, input logic ill, input logic clr);
    if (clr) return ill ? 1 : 0;
    if (ill && cur < 255) return cur + 1;
    return cur;
  endfunction

  // One clock cycle. The bench checks at the falling edge, applies the
  // model for the coming rising edge, then returns 1 ns after that edge.
  task automatic step();
    logic       acc;
    logic       par_ok;
    logic [4:0] e;
    logic [4:0] h;
    @(negedge clk);
`ifdef DECODER_PARITY_EN
    par_ok = (in_par == ^code);
`else
    par_ok = 1'b1;
`endif
    // OUT_N = 4 instance
    check("in_ready4", in_ready4, q4.size() < 2);
    check("out_valid4", out_valid4, q4.size() > 0);
    check("err_count4", err_count4, ecnt4);
    if (q4.size() > 0) begin
      h = q4[0];
      check("out4", out4, h[3:0]);
      check("out_err4", out_err4, h[4]);
    end else begin
      check("out4_idle", out4, 0);
      check("out_err4_idle", out_err4, 0);
    end
    acc = in_valid && (q4.size() < 2);
    if (out_ready && q4.size() > 0) begin
      e = q4.pop_front();
      $display("dut4 pop  out=%b err=%b", e[3:0], e[4]);
    end
    e = model(code, par_ok, 4);
    if (acc) q4.push_back(e);
    ecnt4 = err_model(ecnt4, acc && e[4], err_clr);

    // OUT_N = 3 instance
    check("in_ready3", in_ready3, q3.size() < 2);
    check("out_valid3", out_valid3, q3.size() > 0);
    check("err_count3", err_count3, ecnt3);
    if (q3.size() > 0) begin
      h = q3[0];
      check("out3", out3, h[2:0]);
      check("out_err3", out_err3, h[4]);
    end else begin
      check("out3_idle", out3, 0);
      check("out_err3_idle", out_err3, 0);
    end
    acc = in_valid && (q3.size() < 2);
    if (out_ready && q3.size() > 0) begin
      e = q3.pop_front();
      $display("dut3 pop  out=%b err=%b", e[2:0], e[4]);
    end
    e = model(code, par_ok, 3);
    if (acc) q3.push_back(e);
    ecnt3 = err_model(ecnt3, acc && e[4], err_clr);

    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    err_clr   = 1'b0;
    set_code(2'd0);
    #1 rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_out_valid4", out_valid4, 0);
    check("rst_out4", out4, 0);
    check("rst_out_err4", out_err4, 0);
    check("rst_err_count4", err_count4, 0);
    check("rst_out_valid3", out_valid3, 0);
    check("rst_err_count3", err_count3, 0);
    rst_n = 1'b1;

    // Stream 0,1,2,3 back to back with the sink always ready.
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      set_code(2'(c));
      step();
    end
    in_valid = 1'b0;
    repeat (3) step();

    // Fill both entries against a stalled sink, then drain.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    set_code(2'd2);
    step();
    set_code(2'd3);
    step();
    in_valid = 1'b0;
    repeat (2) step();
    out_ready = 1'b1;
    repeat (3) step();

    // Saturate the illegal-code counter of the OUT_N=3 instance.
    set_code(2'd3);
    in_valid = 1'b1;
    repeat (300) step();
    in_valid = 1'b0;
    repeat (2) step();
    check("err_count3_sat", err_count3, 255);

    // Clear alone, then build up to 5 and clear together with an illegal accept.
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("errclr_alone", err_count3, 0);
    in_valid = 1'b1;
    repeat (5) step();
    err_clr = 1'b1;
    step();
    check("errclr_with_ill", err_count3, 1);
    in_valid = 1'b1;
    err_clr  = 1'b1;
    in_valid = 1'b0;
    step();
    err_clr = 1'b0;
    check("errclr_after", err_count3, 0);
    repeat (3) step();

    // Random traffic with a randomly stalling sink.
    repeat (80) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      err_clr   = ($urandom_range(0, 15) == 0);
      set_code(2'($urandom_range(0, 3)));
      step();
    end
    in_valid  = 1'b0;
    err_clr   = 1'b0;
    out_ready = 1'b1;
    repeat (3) step();

`ifdef DECODER_PARITY_EN
    // A parity-bad code is illegal. A code with good parity decodes normally.
    in_valid = 1'b1;
    code     = 2'd1;
    in_par   = 1'b0;
    step();
    in_par = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (2) step();
`endif

    // Fill the buffer, then assert reset between clock edges.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    set_code(2'd1);
    step();
    set_code(2'd3);
    step();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_out_valid4", out_valid4, 0);
    check("async_rst_out4", out4, 0);
    check("async_rst_out_valid3", out_valid3, 0);
    check("async_rst_out_err3", out_err3, 0);
    check("async_rst_err_count3", err_count3, 0);
    q4.delete();
    q3.delete();
    ecnt4 = 0;
    ecnt3 = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (2) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
